fibo_result_checker: RTL and testbench

Hardware self-check unit that sits beside `Data_Mem` and does what the bench does after the CPU halts. When `halt` rises, it reads data-memory words `BASE_ADDR .. BASE_ADDR+N_TERMS-1` one per cycle and compares each word with a Fibonacci value it generates itself. It reports pass/fail with the first failing index and the data read there. This lets gate-level or FPGA runs check the Fibonacci program without `$display`.

---
 rtl/fibo_result_checker.sv | 159 +++++++++++++++
 tb/tb_fibo_result_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_result_checker.sv
// rtl/fibo_result_checker.sv - post-halt Fibonacci self-check of data memory
//
// Purpose:
//   On the rising edge of halt, reads data-memory words BASE_ADDR ..
//   BASE_ADDR+N_TERMS-1 one per cycle and compares each one with an
//   internally generated Fibonacci term (1, 1, 2, 3, 5, ...). Reports
//   pass/fail, the 1-based index of the first mismatch and the word read
//   there. A result is held until rst; later halt edges are ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   halt       in   CPU halt flag; its rising edge starts a scan
//   rd_data    in   memory read data, combinational from rd_addr
//   rd_addr    out  word index presented to memory (registered)
//   rd_en      out  high in every cycle a compare is performed
//   done       out  result valid
//   pass       out  all terms matched
//   fail_idx   out  1-based index of first mismatch, 0 on pass
//   fail_data  out  word read at first mismatch, 0 on pass

module fibo_result_checker #(
    parameter int N_TERMS   = 20,
    parameter int BASE_ADDR = 1,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_idx,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]        LAST_IDX   = 8'(N_TERMS);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam bit                NO_TERMS   = (N_TERMS == 0);

    state_t            state, state_n;
    logic              halt_d;
    logic [7:0]        idx, idx_n;
    logic [DATA_W-1:0] exp_val, exp_n;
    logic [DATA_W-1:0] nxt_val, nxt_n;
    logic [ADDR_W-1:0] rd_addr_n;
    logic              rd_en_n, done_n, pass_n;
    logic [7:0]        fail_idx_n;
    logic [DATA_W-1:0] fail_data_n;
    logic              start;

    // halt_d resets to 0, so a halt that is already high when rst drops
    // is seen as a rising edge on the first post-reset clock.
    assign start = halt & ~halt_d;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        exp_n       = exp_val;
        nxt_n       = nxt_val;
        rd_addr_n   = rd_addr;
        rd_en_n     = rd_en;
        done_n      = done;
        pass_n      = pass;
        fail_idx_n  = fail_idx;
        fail_data_n = fail_data;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (NO_TERMS) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end else begin
                        state_n   = ST_SCAN;
                        idx_n     = 8'd1;
                        exp_n     = DATA_W'(1);
                        nxt_n     = DATA_W'(1);
                        rd_addr_n = BASE;
                        rd_en_n   = 1'b1;
                    end
                end
            end

            ST_SCAN: begin
                if (rd_data == exp_val) begin
                    if (idx == LAST_IDX) begin
                        state_n     = ST_DONE;
                        rd_en_n     = 1'b0;
                        done_n      = 1'b1;
                        pass_n      = 1'b1;
                        fail_idx_n  = 8'd0;
                        fail_data_n = '0;
                    end else begin
                        // Sums wrap modulo 2^DATA_W by design.
                        idx_n     = idx + 8'd1;
                        rd_addr_n = rd_addr + ADDR_W'(1);
                        exp_n     = nxt_val;
                        nxt_n     = exp_val + nxt_val;
                    end
                end else begin
                    state_n     = ST_DONE;
                    rd_en_n     = 1'b0;
                    done_n      = 1'b1;
                    pass_n      = 1'b0;
                    fail_idx_n  = idx;
                    fail_data_n = rd_data;
                end
            end

            ST_DONE: begin
                // Result held; only rst re-arms the checker.
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            halt_d    <= 1'b0;
            idx       <= 8'd0;
            exp_val   <= '0;
            nxt_val   <= '0;
            rd_addr   <= '0;
            rd_en     <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_idx  <= 8'd0;
            fail_data <= '0;
        end else begin
            state     <= state_n;
            halt_d    <= halt;
            idx       <= idx_n;
            exp_val   <= exp_n;
            nxt_val   <= nxt_n;
            rd_addr   <= rd_addr_n;
            rd_en     <= rd_en_n;
            done      <= done_n;
            pass      <= pass_n;
            fail_idx  <= fail_idx_n;
            fail_data <= fail_data_n;
        end
    end

endmodule

// File: tb/tb_fibo_result_checker.sv
// tb/tb_fibo_result_checker.sv - directed bench for fibo_result_checker

module tb_fibo_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        halt0 = 1'b0;
    logic        halt100 = 1'b0;

    logic [63:0] rd_data, rd_addr, fail_data;
    logic        rd_en, done, pass;
    logic [7:0]  fail_idx;

    logic [63:0] rd_data0, rd_addr0, fail_data0;
    logic        rd_en0, done0, pass0;
    logic [7:0]  fail_idx0;

    logic [63:0] rd_data100, rd_addr100, fail_data100;
    logic        rd_en100, done100, pass100;
    logic [7:0]  fail_idx100;

    logic [63:0] mem20  [0:31];
    logic [63:0] mem100 [0:127];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rd_data    = (rd_addr < 64'd32) ? mem20[rd_addr[4:0]] : 64'd0;
    assign rd_data0   = 64'hDEAD_BEEF;
    assign rd_data100 = (rd_addr100 < 64'd128) ? mem100[rd_addr100[6:0]] : 64'd0;

    fibo_result_checker #(.N_TERMS(20), .BASE_ADDR(1), .DATA_W(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .halt(halt), .rd_data(rd_data), .rd_addr(rd_addr),
        .rd_en(rd_en), .done(done), .pass(pass), .fail_idx(fail_idx), .fail_data(fail_data));

    fibo_result_checker #(.N_TERMS(0), .BASE_ADDR(1), .DATA_W(64), .ADDR_W(64)) dut0 (
        .clk(clk), .rst(rst), .halt(halt0), .rd_data(rd_data0), .rd_addr(rd_addr0),
        .rd_en(rd_en0), .done(done0), .pass(pass0), .fail_idx(fail_idx0), .fail_data(fail_data0));

    fibo_result_checker #(.N_TERMS(100), .BASE_ADDR(1), .DATA_W(64), .ADDR_W(64)) dut100 (
        .clk(clk), .rst(rst), .halt(halt100), .rd_data(rd_data100), .rd_addr(rd_addr100),
        .rd_en(rd_en100), .done(done100), .pass(pass100), .fail_idx(fail_idx100), .fail_data(fail_data100));

    task automatic load_mem20();
        logic [63:0] f [0:20];
        f = '{64'd0, 64'd1, 64'd1, 64'd2, 64'd3, 64'd5, 64'd8, 64'd13, 64'd21, 64'd34, 64'd55,
              64'd89, 64'd144, 64'd233, 64'd377, 64'd610, 64'd987, 64'd1597, 64'd2584,
              64'd4181, 64'd6765};
        for (int i = 0; i < 32; i++) mem20[i] = (i <= 20) ? f[i] : 64'd0;
    endtask

    task automatic load_mem100();
        logic [63:0] a, b, t;
        a = 64'd1; b = 64'd1;
        mem100[0] = 64'd0;
        for (int i = 1; i < 128; i++) begin
            mem100[i] = a;
            t = a + b; a = b; b = t;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; halt = 1'b0; halt0 = 1'b0; halt100 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for edge E0, then samples every following negedge until done.
    task automatic run_scan(input int which, input int budget, output int cycles,
                            output int reads, output bit addr_ok, output bit timed_out);
        logic        d, re;
        logic [63:0] a;
        cycles = 0; reads = 0; addr_ok = 1'b1; timed_out = 1'b1;
        @(posedge clk);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            case (which)
                0:       begin d = done;    re = rd_en;    a = rd_addr;    end
                1:       begin d = done0;   re = rd_en0;   a = rd_addr0;   end
                default: begin d = done100; re = rd_en100; a = rd_addr100; end
            endcase
            if (d) begin timed_out = 1'b0; break; end
            cycles++;
            if (re) begin
                if (a !== 64'(reads + 1)) addr_ok = 1'b0;
                reads++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rd_en, done, pass, fail_idx, fail_data, rd_addr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got en=%0b done=%0b pass=%0b idx=%0d data=%0d addr=%0d want all 0",
                               rd_en, done, pass, fail_idx, fail_data, rd_addr);
        end
        n_cmp++;
        if ({done0, pass0, done100, pass100} !== 4'b0) begin
            n_fail++; $display("FAIL reset_other_duts: got %b want 0000", {done0, pass0, done100, pass100});
        end
    endtask

    task automatic test_full_pass();
        int cyc, rds; bit aok, to;
        load_mem20();
        do_reset();
        @(negedge clk) halt = 1'b1;
        run_scan(0, 60, cyc, rds, aok, to);
        n_cmp++; if (to !== 1'b0)  begin n_fail++; $display("FAIL pass_timeout: got %0b want 0", to); end
        n_cmp++; if (rds !== 20)   begin n_fail++; $display("FAIL pass_reads: got %0d want 20", rds); end
        n_cmp++; if (cyc !== 20)   begin n_fail++; $display("FAIL pass_latency: got %0d want 20", cyc); end
        n_cmp++; if (aok !== 1'b1) begin n_fail++; $display("FAIL pass_addr_seq: got %0b want 1", aok); end
        n_cmp++;
        if ({done, pass, rd_en, fail_idx, fail_data} !== {1'b1, 1'b1, 1'b0, 8'd0, 64'd0}) begin
            n_fail++; $display("FAIL pass_result: got done=%0b pass=%0b en=%0b idx=%0d data=%0d want 1 1 0 0 0",
                               done, pass, rd_en, fail_idx, fail_data);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL pass_held: got %b want 11", {done, pass}); end
    endtask

    task automatic test_corrupt7();
        int cyc, rds; bit aok, to;
        load_mem20();
        mem20[7] = 64'd14;
        do_reset();
        @(negedge clk) halt = 1'b1;
        run_scan(0, 60, cyc, rds, aok, to);
        n_cmp++; if (to !== 1'b0)  begin n_fail++; $display("FAIL c7_timeout: got %0b want 0", to); end
        n_cmp++; if (rds !== 7)    begin n_fail++; $display("FAIL c7_reads: got %0d want 7", rds); end
        n_cmp++; if (aok !== 1'b1) begin n_fail++; $display("FAIL c7_addr_seq: got %0b want 1", aok); end
        n_cmp++;
        if ({done, pass, fail_idx, fail_data} !== {1'b1, 1'b0, 8'd7, 64'd14}) begin
            n_fail++; $display("FAIL c7_result: got done=%0b pass=%0b idx=%0d data=%0d want 1 0 7 14",
                               done, pass, fail_idx, fail_data);
        end
        load_mem20();
    endtask

    task automatic test_word1_zero();
        int cyc, rds; bit aok, to;
        load_mem20();
        mem20[1] = 64'd0;
        do_reset();
        @(negedge clk) halt = 1'b1;
        run_scan(0, 60, cyc, rds, aok, to);
        n_cmp++; if (rds !== 1) begin n_fail++; $display("FAIL w1_reads: got %0d want 1", rds); end
        n_cmp++;
        if ({to, done, pass, fail_idx, fail_data} !== {1'b0, 1'b1, 1'b0, 8'd1, 64'd0}) begin
            n_fail++; $display("FAIL w1_result: got to=%0b done=%0b pass=%0b idx=%0d data=%0d want 0 1 0 1 0",
                               to, done, pass, fail_idx, fail_data);
        end
        load_mem20();
    endtask

    task automatic test_halt_at_reset();
        int cyc, rds, extra; bit aok, to;
        load_mem20();
        @(negedge clk);
        rst = 1'b1; halt = 1'b1; halt0 = 1'b0; halt100 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run_scan(0, 60, cyc, rds, aok, to);
        n_cmp++;
        if ({to, rds, cyc, aok, done, pass} !== {1'b0, 32'd20, 32'd20, 1'b1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL halt_at_reset: got to=%0b reads=%0d cyc=%0d aok=%0b done=%0b pass=%0b want 0 20 20 1 1 1",
                               to, rds, cyc, aok, done, pass);
        end
        @(negedge clk) halt = 1'b0;
        repeat (3) @(negedge clk);
        halt = 1'b1;
        extra = 0;
        repeat (10) begin @(negedge clk); if (rd_en) extra++; end
        n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL rehalt_reads: got %0d want 0", extra); end
        n_cmp++;
        if ({done, pass, fail_idx, fail_data} !== {1'b1, 1'b1, 8'd0, 64'd0}) begin
            n_fail++; $display("FAIL rehalt_result: got done=%0b pass=%0b idx=%0d data=%0d want 1 1 0 0",
                               done, pass, fail_idx, fail_data);
        end
    endtask

    task automatic test_reset_midscan();
        int cyc, rds, stray; bit aok, to;
        load_mem20();
        do_reset();
        @(negedge clk) halt = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; halt = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_en, rd_addr} !== {1'b1, 64'd5}) begin
            n_fail++; $display("FAIL mid_5th_cycle: got en=%0b addr=%0d want 1 5", rd_en, rd_addr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_en, done, pass, fail_idx, fail_data, rd_addr} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got en=%0b done=%0b pass=%0b idx=%0d data=%0d addr=%0d want all 0",
                               rd_en, done, pass, fail_idx, fail_data, rd_addr);
        end
        stray = 0;
        repeat (3) begin @(negedge clk); if (rd_en || done) stray++; end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL mid_idle: got %0d active cycles want 0", stray); end
        halt = 1'b1;
        run_scan(0, 60, cyc, rds, aok, to);
        n_cmp++;
        if ({to, rds, aok, done, pass} !== {1'b0, 32'd20, 1'b1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL mid_rescan: got to=%0b reads=%0d aok=%0b done=%0b pass=%0b want 0 20 1 1 1",
                               to, rds, aok, done, pass);
        end
    endtask

    task automatic test_nterms0();
        int en_seen;
        do_reset();
        @(negedge clk);
        n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL n0_before: got %0b want 0", done0); end
        halt0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({done0, pass0, rd_en0, fail_idx0, fail_data0} !== {1'b1, 1'b1, 1'b0, 8'd0, 64'd0}) begin
            n_fail++; $display("FAIL n0_result: got done=%0b pass=%0b en=%0b idx=%0d data=%0d want 1 1 0 0 0",
                               done0, pass0, rd_en0, fail_idx0, fail_data0);
        end
        en_seen = 0;
        repeat (5) begin @(negedge clk); if (rd_en0) en_seen++; end
        n_cmp++; if (en_seen !== 0) begin n_fail++; $display("FAIL n0_rd_en: got %0d want 0", en_seen); end
    endtask

    task automatic test_nterms100();
        int cyc, rds; bit aok, to;
        load_mem100();
        do_reset();
        @(negedge clk) halt100 = 1'b1;
        run_scan(2, 200, cyc, rds, aok, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL n100_timeout: got %0b want 0", to); end
        n_cmp++;
        if ({rds, cyc, aok, pass100, fail_idx100} !== {32'd100, 32'd100, 1'b1, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL n100_result: got reads=%0d cyc=%0d aok=%0b pass=%0b idx=%0d want 100 100 1 1 0",
                               rds, cyc, aok, pass100, fail_idx100);
        end
        // f(94) wrapped to 64 bits; a checker without wrap must fail here.
        mem100[94] = 64'd1293530146158671551;
        do_reset();
        @(negedge clk) halt100 = 1'b1;
        run_scan(2, 200, cyc, rds, aok, to);
        n_cmp++;
        if ({to, pass100, rds} !== {1'b0, 1'b1, 32'd100}) begin
            n_fail++; $display("FAIL n100_wrap_const: got to=%0b pass=%0b reads=%0d want 0 1 100", to, pass100, rds);
        end
        mem100[94] = 64'd1293530146158671552;
        do_reset();
        @(negedge clk) halt100 = 1'b1;
        run_scan(2, 200, cyc, rds, aok, to);
        n_cmp++;
        if ({to, pass100, fail_idx100, fail_data100} !== {1'b0, 1'b0, 8'd94, 64'd1293530146158671552}) begin
            n_fail++; $display("FAIL n100_bad94: got to=%0b pass=%0b idx=%0d data=%0d want 0 0 94 1293530146158671552",
                               to, pass100, fail_idx100, fail_data100);
        end
    endtask

    initial begin
        load_mem20();
        load_mem100();
        test_reset();
        test_full_pass();
        test_corrupt7();
        test_word1_zero();
        test_halt_at_reset();
        test_reset_midscan();
        test_nterms0();
        test_nterms100();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
